// File: rtl/tt_sel_driver.sv
// Host-side driver for the mux chip's design-select pins: reset the select counter, pulse increment A times, raise enable.
// Optional macro TT_SEL_DELTA_EN: when already on a lower address, step forward from it instead of resetting.
module tt_sel_driver #(
    parameter int ADDR_W    = 10,
    parameter int PULSE_CYC = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic              req_ena,
    output logic              done,
    output logic              cur_valid,
    output logic [ADDR_W-1:0] cur_addr,
    output logic              ctrl_sel_rst_n,
    output logic              ctrl_sel_inc,
    output logic              ctrl_ena
);

    localparam int PH_W = $clog2(PULSE_CYC) + 1;
    localparam logic [PH_W-1:0]   PH_LOAD  = PH_W'(PULSE_CYC - 1);
    localparam logic [PH_W-1:0]   PH_ZERO  = {PH_W{1'b0}};
    localparam logic [ADDR_W-1:0] CNT_ZERO = {ADDR_W{1'b0}};
    localparam logic [ADDR_W-1:0] CNT_ONE  = ADDR_W'(1);

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_RST_LO  = 3'd1,
        S_SETTLE  = 3'd2,
        S_INC_HI  = 3'd3,
        S_INC_LO  = 3'd4,
        S_FINISH  = 3'd5
`ifdef TT_SEL_DELTA_EN
        , S_ENA_OFF = 3'd6
`endif
    } state_t;

    state_t            state_r;
    logic [PH_W-1:0]   phase_r;
    logic [ADDR_W-1:0] inc_cnt_r;
    logic [ADDR_W-1:0] addr_r;
    logic              ena_req_r;
    logic              phase_end_s;

    assign phase_end_s = (phase_r == PH_ZERO);

    // Sequencer FSM; every pin and status output is written here as a register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r        <= S_IDLE;
            phase_r        <= PH_ZERO;
            inc_cnt_r      <= CNT_ZERO;
            addr_r         <= CNT_ZERO;
            ena_req_r      <= 1'b0;
            req_ready      <= 1'b1;
            done           <= 1'b0;
            cur_valid      <= 1'b0;
            cur_addr       <= CNT_ZERO;
            ctrl_sel_rst_n <= 1'b0;
            ctrl_sel_inc   <= 1'b0;
            ctrl_ena       <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state_r)
                // FINISH already reports ready, so it accepts exactly like IDLE.
                S_IDLE, S_FINISH: begin
                    if (req_valid) begin
                        addr_r    <= req_addr;
                        ena_req_r <= req_ena;
                        req_ready <= 1'b0;
                        ctrl_ena  <= 1'b0;
                        phase_r   <= PH_LOAD;
`ifdef TT_SEL_DELTA_EN
                        if (cur_valid && (req_addr >= cur_addr)) begin
                            state_r   <= S_ENA_OFF;
                            inc_cnt_r <= req_addr - cur_addr;
                        end else begin
                            state_r        <= S_RST_LO;
                            inc_cnt_r      <= req_addr;
                            ctrl_sel_rst_n <= 1'b0;
                            ctrl_sel_inc   <= 1'b0;
                        end
`else
                        state_r        <= S_RST_LO;
                        inc_cnt_r      <= req_addr;
                        ctrl_sel_rst_n <= 1'b0;
                        ctrl_sel_inc   <= 1'b0;
`endif
                    end else begin
                        state_r <= S_IDLE;
                    end
                end
                S_RST_LO: begin
                    if (phase_end_s) begin
                        state_r        <= S_SETTLE;
                        phase_r        <= PH_LOAD;
                        ctrl_sel_rst_n <= 1'b1;
                    end else begin
                        phase_r <= phase_r - PH_W'(1);
                    end
                end
                S_SETTLE: begin
                    if (!phase_end_s) begin
                        phase_r <= phase_r - PH_W'(1);
                    end else if (inc_cnt_r == CNT_ZERO) begin
                        state_r   <= S_FINISH;
                        done      <= 1'b1;
                        req_ready <= 1'b1;
                        ctrl_ena  <= ena_req_r;
                        cur_valid <= 1'b1;
                        cur_addr  <= addr_r;
                    end else begin
                        state_r      <= S_INC_HI;
                        phase_r      <= PH_LOAD;
                        ctrl_sel_inc <= 1'b1;
                    end
                end
`ifdef TT_SEL_DELTA_EN
                S_ENA_OFF: begin
                    if (!phase_end_s) begin
                        phase_r <= phase_r - PH_W'(1);
                    end else if (inc_cnt_r == CNT_ZERO) begin
                        state_r   <= S_FINISH;
                        done      <= 1'b1;
                        req_ready <= 1'b1;
                        ctrl_ena  <= ena_req_r;
                        cur_valid <= 1'b1;
                        cur_addr  <= addr_r;
                    end else begin
                        state_r      <= S_INC_HI;
                        phase_r      <= PH_LOAD;
                        ctrl_sel_inc <= 1'b1;
                    end
                end
`endif
                S_INC_HI: begin
                    if (phase_end_s) begin
                        state_r      <= S_INC_LO;
                        phase_r      <= PH_LOAD;
                        ctrl_sel_inc <= 1'b0;
                    end else begin
                        phase_r <= phase_r - PH_W'(1);
                    end
                end
                // The count stops at zero on the last low phase, so it can never wrap.
                S_INC_LO: begin
                    if (!phase_end_s) begin
                        phase_r <= phase_r - PH_W'(1);
                    end else if (inc_cnt_r == CNT_ONE) begin
                        inc_cnt_r <= CNT_ZERO;
                        state_r   <= S_FINISH;
                        done      <= 1'b1;
                        req_ready <= 1'b1;
                        ctrl_ena  <= ena_req_r;
                        cur_valid <= 1'b1;
                        cur_addr  <= addr_r;
                    end else begin
                        inc_cnt_r    <= inc_cnt_r - CNT_ONE;
                        state_r      <= S_INC_HI;
                        phase_r      <= PH_LOAD;
                        ctrl_sel_inc <= 1'b1;
                    end
                end
                default: begin
                    state_r        <= S_IDLE;
                    phase_r        <= PH_ZERO;
                    req_ready      <= 1'b1;
                    ctrl_sel_inc   <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_tt_sel_driver.sv
// Randomized and directed bench for tt_sel_driver against a per-cycle pin-waveform reference model.
module tb_tt_sel_driver;

    localparam int AW = 10;
    localparam int P  = 4;

    logic          clk = 1'b0;
    logic          rst;
    logic          req_valid;
    logic          req_ready;
    logic [AW-1:0] req_addr;
    logic          req_ena;
    logic          done;
    logic          cur_valid;
    logic [AW-1:0] cur_addr;
    logic          ctrl_sel_rst_n;
    logic          ctrl_sel_inc;
    logic          ctrl_ena;

    always #5 clk = ~clk;

    tt_sel_driver #(.ADDR_W(AW), .PULSE_CYC(P)) dut (
        .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready),
        .req_addr(req_addr), .req_ena(req_ena), .done(done),
        .cur_valid(cur_valid), .cur_addr(cur_addr),
        .ctrl_sel_rst_n(ctrl_sel_rst_n), .ctrl_sel_inc(ctrl_sel_inc), .ctrl_ena(ctrl_ena)
    );

    typedef struct packed {
        logic          rst_n;
        logic          inc;
        logic          ena;
        logic          done;
        logic          ready;
        logic          cv;
        logic [AW-1:0] ca;
    } pins_t;

    pins_t exp_q[$];
    pins_t m_cur;
    int    n_vec = 0;
    int    n_err = 0;

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s @%0t: got %0h expected %0h", tag, $time, obs, exp);
        end
    endtask

    function automatic pins_t reset_pins();
        pins_t p;
        p.rst_n = 1'b0; p.inc = 1'b0; p.ena = 1'b0; p.done = 1'b0;
        p.ready = 1'b1; p.cv = 1'b0; p.ca = '0;
        return p;
    endfunction

    // Expected waveform of a whole selection, one entry per cycle after the accept edge.
    task automatic plan(input logic [AW-1:0] a, input logic e);
        pins_t p;
        int    n;
        p = m_cur;
        p.done = 1'b0; p.ready = 1'b0; p.inc = 1'b0; p.ena = 1'b0;
`ifdef TT_SEL_DELTA_EN
        if (m_cur.cv && a >= m_cur.ca) begin
            repeat (P) exp_q.push_back(p);
            n = int'(a) - int'(m_cur.ca);
        end else
`endif
        begin
            p.rst_n = 1'b0;
            repeat (P) exp_q.push_back(p);
            p.rst_n = 1'b1;
            repeat (P) exp_q.push_back(p);
            n = int'(a);
        end
        for (int i = 0; i < n; i++) begin
            p.inc = 1'b1;
            repeat (P) exp_q.push_back(p);
            p.inc = 1'b0;
            repeat (P) exp_q.push_back(p);
        end
        p.ena = e; p.done = 1'b1; p.ready = 1'b1; p.cv = 1'b1; p.ca = a;
        exp_q.push_back(p);
    endtask

    task automatic step();
        @(posedge clk);
        if (rst) begin
            exp_q.delete();
            m_cur = reset_pins();
        end else begin
            if (req_valid && m_cur.ready) plan(req_addr, req_ena);
            if (exp_q.size() > 0) begin
                m_cur = exp_q.pop_front();
            end else begin
                m_cur.done  = 1'b0;
                m_cur.ready = 1'b1;
            end
        end
        #1;
        check_val("rst_n", 32'(ctrl_sel_rst_n), 32'(m_cur.rst_n));
        check_val("inc",   32'(ctrl_sel_inc),   32'(m_cur.inc));
        check_val("ena",   32'(ctrl_ena),       32'(m_cur.ena));
        check_val("done",  32'(done),           32'(m_cur.done));
        check_val("ready", 32'(req_ready),      32'(m_cur.ready));
        check_val("cur_valid", 32'(cur_valid),  32'(m_cur.cv));
        check_val("cur_addr",  32'(cur_addr),   32'(m_cur.ca));
    endtask

    task automatic drain();
        for (int i = 0; i < 20000 && exp_q.size() > 0; i++) step();
        step();
    endtask

    // Issue one request from idle and check the accept-to-done latency formula.
    task automatic req(input logic [AW-1:0] a, input logic e);
        int exp_lat;
        int lat;
        exp_lat = 2 * P + 2 * P * int'(a) + 1;
`ifdef TT_SEL_DELTA_EN
        if (m_cur.cv && a >= m_cur.ca) exp_lat = P + 2 * P * (int'(a) - int'(m_cur.ca)) + 1;
`endif
        req_valid = 1'b1; req_addr = a; req_ena = e;
        step();
        req_valid = 1'b0;
        lat = 1;
        while (done !== 1'b1 && lat < exp_lat + 8) begin
            step();
            lat++;
        end
        check_val("done_lat", 32'(lat), 32'(exp_lat));
    endtask

    initial begin
        m_cur = reset_pins();
        rst = 1'b1; req_valid = 1'b0; req_addr = '0; req_ena = 1'b0;
        step();
        step();
        rst = 1'b0;
        step();

        req(10'd3, 1'b1);
        req(10'd0, 1'b1);
        req(10'd5, 1'b0);
        drain();

        // Requests while busy are dropped; a later request starts over.
        rst = 1'b1; step(); rst = 1'b0; step();
        req_valid = 1'b1; req_addr = 10'd3; req_ena = 1'b1;
        step();
        req_addr = 10'd7;
        repeat (20) step();
        req_valid = 1'b0;
        drain();
        req(10'd7, 1'b1);
        drain();

        // Reset mid-sequence abandons it.
        rst = 1'b1; step(); rst = 1'b0; step();
        req_valid = 1'b1; req_addr = 10'd3; req_ena = 1'b1;
        step();
        req_valid = 1'b0;
        repeat (19) step();
        rst = 1'b1; step(); rst = 1'b0;
        repeat (5) step();

        req(10'd3, 1'b1);
        req(10'd6, 1'b1);
        req(10'd2, 1'b1);
        req(10'd2, 1'b0);
        drain();

        for (int i = 0; i < 600; i++) begin
            rst       = ($urandom_range(0, 199) == 0);
            req_valid = ($urandom_range(0, 3) == 0);
            req_addr  = AW'($urandom_range(0, 6));
            req_ena   = 1'($urandom);
            step();
        end
        rst = 1'b0; req_valid = 1'b0;
        drain();

        rst = 1'b1; step(); rst = 1'b0; step();
        req(10'd1023, 1'b1);
        drain();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
